// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch/decode/execute/mem/writeback,
// drives datapath strobes and memory handshakes, keeps cycle/retire counters and halts on faults.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic             dec_reg_write,
  input  logic             dec_mem_read,
  input  logic             dec_mem_write,
  input  logic             dec_is_branch,
  input  logic             dec_is_jump,
  input  logic             dec_illegal,
  input  logic             branch_taken,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_enable,
  output logic             pc_load,
  input  logic             halt_req,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret
);

  localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;
  localparam logic [1:0] FAULT_HALT    = 2'd3;

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        fault_q, fault_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              timeout_c;
  logic              redirect_c;

  // Limit reached this cycle; a same-cycle ack takes priority in the next-state logic
  assign timeout_c  = (MEM_TIMEOUT != 0) && ((wait_q + WAIT_W'(1)) == WAIT_LIMIT);
  assign redirect_c = dec_is_jump | (dec_is_branch & branch_taken);

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    wait_d    = wait_q;
    cycle_d   = cycle_q;
    instret_d = instret_q;

    case (state_q)
      S_RESET:   state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_d = S_DECODE;
        end else if (timeout_c) begin
          state_d = S_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (dec_illegal || (dec_mem_read && dec_mem_write)) begin
          state_d = S_HALT;
          fault_d = FAULT_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: state_d = (dec_mem_read || dec_mem_write) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (timeout_c) begin
          state_d = S_HALT;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_WB: begin
        instret_d = instret_q + CNT_W'(1);
        if (halt_req) begin
          state_d = S_HALT;
          fault_d = FAULT_HALT;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_RESET;
    endcase

    // Wait counter tracks consecutive cycles spent in a request state
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (state_q == S_FETCH || state_q == S_MEM) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    if (state_q != S_RESET && state_q != S_HALT) begin
      cycle_d = cycle_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      fault_q   <= FAULT_NONE;
      wait_q    <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  // Strobes decode the registered state only, so reset drops them immediately
  assign imem_req    = (state_q == S_FETCH);
  assign ir_load     = (state_q == S_FETCH) & imem_ack;
  assign dmem_req    = (state_q == S_MEM);
  assign dmem_we     = (state_q == S_MEM) & dec_mem_write;
  assign rf_we       = (state_q == S_WB) & dec_reg_write;
  assign pc_load     = (state_q == S_WB) & redirect_c;
  assign pc_enable   = (state_q == S_WB) & ~redirect_c;
  assign halted      = (state_q == S_HALT);
  assign fault       = fault_q;
  assign state_o     = 3'(state_q);
  assign cycle_count = cycle_q;
  assign instret     = instret_q;

endmodule
